mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of bus-wait cycles before a transaction is aborted (range 1..255, 8-bit counter).
REQ-002 The block SHALL have parameter D_BURST_MAX, default 2, meaning the number of consecutive data grants allowed while a fetch request is pending.
REQ-003 clk  in  1  the only clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 if_req_i  in  1  fetch request, level, held until if_ack_o.
REQ-006 if_addr_i  in  32  fetch address.
REQ-007 if_rdata_o  out  32  fetch data, valid while if_ack_o=1.
REQ-008 if_ack_o  out  1  fetch completion pulse.
REQ-009 dm_req_i  in  1  data request, level, held until dm_ack_o.
REQ-010 dm_we_i, dm_sel_i, dm_addr_i, dm_wdata_i  in  1/4/32/32  data write-enable, byte select, address and write data.
REQ-011 dm_rdata_o  out  32  data read result; dm_ack_o  out  1  data completion pulse.
REQ-012 bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o  out  1/1/4/32/32  shared memory port, all registered.
REQ-013 bus_rdata_i  in  32, bus_ack_i  in  1  memory response.
REQ-014 flush_i  in  1  pipeline flush; discards any fetch in flight.
REQ-015 err_o  out  1  qualifies if_ack_o/dm_ack_o as a timeout abort.
REQ-016 stallreq_o  out  1  stall request to the pipeline controller.

Function
REQ-017 The FSM SHALL have states IDLE, I_BUSY and D_BUSY.
REQ-018 In IDLE, a data request SHALL have priority over a fetch request, except that a pending fetch SHALL win once D_BURST_MAX consecutive data grants have occurred while it waited.
REQ-019 A port whose ack_o is 1 in the current cycle SHALL NOT be granted in that cycle (the held-over request is ignored).
REQ-020 On a grant, the block SHALL latch address/we/sel/wdata into the bus registers and assert bus_req_o from the next cycle.
REQ-021 Fetch grants SHALL drive bus_we_o=0 and bus_sel_o=4'hF.
REQ-022 Bus outputs SHALL remain stable while bus_req_o=1 and bus_ack_i=0.
REQ-023 On bus_ack_i=1 in a BUSY state, the block SHALL do the following on the next edge: clear bus_req_o, register bus_rdata_i to the owning port's rdata, pulse that port's ack_o for exactly 1 cycle, and return to IDLE.
REQ-024 Minimum latency SHALL be: request sampled at cycle N, bus_req_o=1 at N+1, ack_o=1 at N+2 when bus_ack_i=1 at N+1.
REQ-025 dm_rdata_o SHALL be 0 on write completions; rdata outputs SHALL hold their value between acks.
REQ-026 A wait counter SHALL clear on grant and increment each BUSY cycle without bus_ack_i; on reaching TIMEOUT, the block SHALL clear bus_req_o, pulse ack_o with err_o=1 and rdata=0, and return to IDLE.
REQ-027 flush_i=1 in IDLE SHALL suppress a fetch grant that cycle.
REQ-028 flush_i=1 in I_BUSY SHALL set a discard flag, and the transaction SHALL still wait for bus_ack_i or a timeout.
REQ-029 Completion with the discard flag set SHALL NOT pulse if_ack_o, and SHALL clear the flag.
REQ-030 flush_i SHALL NOT affect D_BUSY.
REQ-031 bus_ack_i SHALL be ignored in IDLE.
REQ-032 stallreq_o SHALL equal (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinationally.

Reset
REQ-033 With rst=1 at a clock edge, the FSM SHALL enter IDLE, all outputs except stallreq_o SHALL be 0, and the counters and discard flag SHALL be 0, including when reset arrives mid-transaction.
REQ-034 Any bus_ack_i after reset SHALL be ignored.

Verification
REQ-035 Single fetch: if_req_i=1, if_addr_i=0x0000_0040, bus_ack_i one cycle after bus_req_o with rdata 0x2401_0005 -> bus_addr_o=0x40, bus_sel_o=F, if_ack_o pulse, if_rdata_o=0x2401_0005.
REQ-036 Simultaneous requests: if_req_i and dm_req_i (write 0xDEAD_BEEF to 0x100, sel=4'b0011) both high -> write issued first with bus_we_o=1, then the fetch; no grant is repeated on an ack cycle.
REQ-037 Starvation guard: dm_req_i held high continuously with if_req_i pending, D_BURST_MAX=2 -> third grant goes to fetch.
REQ-038 Timeout: TIMEOUT=4, bus_ack_i never asserted -> after 4 wait cycles bus_req_o=0, dm_ack_o=1, err_o=1, dm_rdata_o=0.
REQ-039 Flush: flush_i pulsed during I_BUSY, then bus_ack_i -> no if_ack_o, next data request granted normally.
REQ-040 Reset mid-D_BUSY, then bus_ack_i -> no ack pulse, all outputs 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Instruction/data memory arbiter onto one shared bus port.
// Registered bus side, per-port ack pulses, timeout and fetch flush.
module mem_arbiter #(
  parameter int TIMEOUT     = 255,
  parameter int D_BURST_MAX = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_sel_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  input  logic        flush_i,
  output logic        err_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } state_t;

  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [7:0] BURST_LIM = 8'(D_BURST_MAX);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  burst_q, burst_d;
  logic        disc_q, disc_d;

  logic        breq_d;
  logic        bwe_d;
  logic [3:0]  bsel_d;
  logic [31:0] baddr_d;
  logic [31:0] bwdata_d;
  logic [31:0] if_rdata_d;
  logic [31:0] dm_rdata_d;
  logic        if_ack_d;
  logic        dm_ack_d;
  logic        err_d;

  logic        sel_fetch;
  logic        grant_i;
  logic        grant_d;
  logic        if_pend;
  logic        timeout;
  logic        drop;

  // Priority is decided on raw request levels; a port in its ack
  // cycle is then masked, so its held-over request still blocks
  // the lower-priority port instead of letting it slip in.
  assign sel_fetch = if_req_i &
                     (~dm_req_i | (burst_q >= BURST_LIM));
  assign grant_i   = sel_fetch & ~if_ack_o & ~flush_i;
  assign grant_d   = ~sel_fetch & dm_req_i & ~dm_ack_o;
  assign if_pend   = if_req_i & ~if_ack_o;
  assign timeout   = (wait_q == TO_LAST);
  assign drop      = disc_q | flush_i;

  assign stallreq_o = (if_req_i & ~if_ack_o) |
                      (dm_req_i & ~dm_ack_o);

  // Next-state and next-output decode for every registered signal.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    burst_d    = burst_q;
    disc_d     = disc_q;
    breq_d     = bus_req_o;
    bwe_d      = bus_we_o;
    bsel_d     = bus_sel_o;
    baddr_d    = bus_addr_o;
    bwdata_d   = bus_wdata_o;
    if_rdata_d = if_rdata_o;
    dm_rdata_d = dm_rdata_o;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        disc_d = 1'b0;
        if (grant_d) begin
          state_d  = D_BUSY;
          breq_d   = 1'b1;
          bwe_d    = dm_we_i;
          bsel_d   = dm_sel_i;
          baddr_d  = dm_addr_i;
          bwdata_d = dm_wdata_i;
          wait_d   = 8'd0;
          if (if_pend) begin
            if (burst_q != 8'hFF) begin
              burst_d = burst_q + 8'd1;
            end
          end else begin
            burst_d = 8'd0;
          end
        end else if (grant_i) begin
          state_d  = I_BUSY;
          breq_d   = 1'b1;
          bwe_d    = 1'b0;
          bsel_d   = 4'hF;
          baddr_d  = if_addr_i;
          bwdata_d = 32'd0;
          wait_d   = 8'd0;
          burst_d  = 8'd0;
        end else if (!if_req_i) begin
          burst_d = 8'd0;
        end
      end
      I_BUSY: begin
        if (flush_i) begin
          disc_d = 1'b1;
        end
        if (bus_ack_i) begin
          state_d = IDLE;
          breq_d  = 1'b0;
          disc_d  = 1'b0;
          if (!drop) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus_rdata_i;
          end
        end else if (timeout) begin
          state_d = IDLE;
          breq_d  = 1'b0;
          disc_d  = 1'b0;
          if (!drop) begin
            if_ack_d   = 1'b1;
            err_d      = 1'b1;
            if_rdata_d = 32'd0;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      D_BUSY: begin
        if (bus_ack_i) begin
          state_d    = IDLE;
          breq_d     = 1'b0;
          dm_ack_d   = 1'b1;
          dm_rdata_d = bus_we_o ? 32'd0 : bus_rdata_i;
        end else if (timeout) begin
          state_d    = IDLE;
          breq_d     = 1'b0;
          dm_ack_d   = 1'b1;
          err_d      = 1'b1;
          dm_rdata_d = 32'd0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        breq_d  = 1'b0;
      end
    endcase
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= 8'd0;
      burst_q     <= 8'd0;
      disc_q      <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= 4'd0;
      bus_addr_o  <= 32'd0;
      bus_wdata_o <= 32'd0;
      if_rdata_o  <= 32'd0;
      dm_rdata_o  <= 32'd0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      burst_q     <= burst_d;
      disc_q      <= disc_d;
      bus_req_o   <= breq_d;
      bus_we_o    <= bwe_d;
      bus_sel_o   <= bsel_d;
      bus_addr_o  <= baddr_d;
      bus_wdata_o <= bwdata_d;
      if_rdata_o  <= if_rdata_d;
      dm_rdata_o  <= dm_rdata_d;
      if_ack_o    <= if_ack_d;
      dm_ack_o    <= dm_ack_d;
      err_o       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Small TIMEOUT keeps the abort scenario short.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [3:0]  dm_sel_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        flush_i;
  logic        err_o;
  logic        stallreq_o;

  int checks = 0;
  int failures = 0;

  logic [136:0] outs;
  assign outs = {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o,
                 bus_wdata_o, if_rdata_o, if_ack_o, dm_rdata_o,
                 dm_ack_o, err_o};

  mem_arbiter #(
    .TIMEOUT(4),
    .D_BURST_MAX(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req_i(if_req_i),
    .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o),
    .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i),
    .dm_we_i(dm_we_i),
    .dm_sel_i(dm_sel_i),
    .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o),
    .dm_ack_o(dm_ack_o),
    .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i),
    .flush_i(flush_i),
    .err_o(err_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=0", outs);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (outs !== '0 || stallreq_o !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got=%h stall=%b exp=0",
               outs, stallreq_o);
    end
    if_req_i = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b1) begin
      failures++;
      $display("FAIL stall_comb got=%b exp=1", stallreq_o);
    end
    if_req_i = 1'b0;
    #1;
  endtask

  task automatic test_single_fetch();
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0040;
    tick();
    checks++;
    if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o} !==
        {1'b1, 1'b0, 4'hF, 32'h40}) begin
      failures++;
      $display("FAIL fetch_issue got=%b%b%h_%h exp=10f_00000040",
               bus_req_o, bus_we_o, bus_sel_o, bus_addr_o);
    end
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h2401_0005;
    tick();
    checks++;
    if ({if_ack_o, bus_req_o, err_o, if_rdata_o, stallreq_o} !==
        {3'b100, 32'h2401_0005, 1'b0}) begin
      failures++;
      $display("FAIL fetch_ack got=%b%b%b %h %b exp=100 24010005 0",
               if_ack_o, bus_req_o, err_o, if_rdata_o, stallreq_o);
    end
    bus_ack_i = 1'b0;
    tick();
    checks++;
    if ({if_ack_o, bus_req_o, if_rdata_o} !==
        {2'b00, 32'h2401_0005}) begin
      failures++;
      $display("FAIL fetch_no_regrant got=%b%b %h exp=00 24010005",
               if_ack_o, bus_req_o, if_rdata_o);
    end
    if_req_i = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    if_req_i   = 1'b1;
    if_addr_i  = 32'h0000_0080;
    dm_req_i   = 1'b1;
    dm_we_i    = 1'b1;
    dm_sel_i   = 4'b0011;
    dm_addr_i  = 32'h0000_0100;
    dm_wdata_i = 32'hDEAD_BEEF;
    tick();
    checks++;
    if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o} !==
        {2'b11, 4'h3, 32'h100, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL sim_write got=%b%b%h %h %h exp=113 100 deadbeef",
               bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o);
    end
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'hFFFF_0000;
    tick();
    checks++;
    if ({dm_ack_o, if_ack_o, dm_rdata_o} !== {2'b10, 32'h0}) begin
      failures++;
      $display("FAIL sim_wr_ack got=%b%b %h exp=10 00000000",
               dm_ack_o, if_ack_o, dm_rdata_o);
    end
    bus_ack_i = 1'b0;
    tick();
    checks++;
    if (bus_req_o !== 1'b0) begin
      failures++;
      $display("FAIL sim_ack_cycle got=%b exp=0", bus_req_o);
    end
    dm_req_i = 1'b0;
    tick();
    checks++;
    if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o} !==
        {2'b10, 4'hF, 32'h80}) begin
      failures++;
      $display("FAIL sim_fetch got=%b%b%h %h exp=10f 00000080",
               bus_req_o, bus_we_o, bus_sel_o, bus_addr_o);
    end
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h1111_2222;
    tick();
    checks++;
    if ({if_ack_o, if_rdata_o} !== {1'b1, 32'h1111_2222}) begin
      failures++;
      $display("FAIL sim_fetch_ack got=%b %h exp=1 11112222",
               if_ack_o, if_rdata_o);
    end
    bus_ack_i = 1'b0;
    if_req_i  = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0200;
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_sel_i  = 4'hF;
    dm_addr_i = 32'h0000_0300;
    for (int g = 0; g < 2; g++) begin
      tick();
      checks++;
      if ({bus_req_o, bus_we_o, bus_addr_o} !== {2'b10, 32'h300}) begin
        failures++;
        $display("FAIL starve_d%0d got=%b%b %h exp=10 00000300",
                 g, bus_req_o, bus_we_o, bus_addr_o);
      end
      bus_ack_i   = 1'b1;
      bus_rdata_i = 32'hA000_0000 + 32'(g);
      tick();
      checks++;
      if ({dm_ack_o, dm_rdata_o} !== {1'b1, 32'hA000_0000 + 32'(g)}) begin
        failures++;
        $display("FAIL starve_dack%0d got=%b %h exp=1 %h",
                 g, dm_ack_o, dm_rdata_o, 32'hA000_0000 + 32'(g));
      end
      bus_ack_i = 1'b0;
      if (g == 0) begin
        tick();
        checks++;
        if (bus_req_o !== 1'b0) begin
          failures++;
          $display("FAIL starve_gap got=%b exp=0", bus_req_o);
        end
      end
    end
    tick();
    checks++;
    if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o} !==
        {2'b10, 4'hF, 32'h200}) begin
      failures++;
      $display("FAIL starve_fetch got=%b%b%h %h exp=10f 00000200",
               bus_req_o, bus_we_o, bus_sel_o, bus_addr_o);
    end
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'hC0DE_0001;
    tick();
    checks++;
    if ({if_ack_o, if_rdata_o} !== {1'b1, 32'hC0DE_0001}) begin
      failures++;
      $display("FAIL starve_fack got=%b %h exp=1 c0de0001",
               if_ack_o, if_rdata_o);
    end
    bus_ack_i = 1'b0;
    if_req_i  = 1'b0;
    tick();
    checks++;
    if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h300}) begin
      failures++;
      $display("FAIL starve_dresume got=%b %h exp=1 00000300",
               bus_req_o, bus_addr_o);
    end
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h5555_AAAA;
    tick();
    bus_ack_i = 1'b0;
    dm_req_i  = 1'b0;
    tick();
    checks++;
    if (dm_rdata_o !== 32'h5555_AAAA) begin
      failures++;
      $display("FAIL starve_hold got=%h exp=5555aaaa", dm_rdata_o);
    end
  endtask

  task automatic test_timeout();
    dm_req_i    = 1'b1;
    dm_we_i     = 1'b0;
    dm_addr_i   = 32'h0000_0400;
    bus_rdata_i = 32'h9999_9999;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({bus_req_o, dm_ack_o, err_o} !== 3'b100) begin
        failures++;
        $display("FAIL tmo_wait%0d got=%b%b%b exp=100",
                 c, bus_req_o, dm_ack_o, err_o);
      end
    end
    tick();
    checks++;
    if ({bus_req_o, dm_ack_o, err_o, dm_rdata_o} !== {3'b011, 32'h0}) begin
      failures++;
      $display("FAIL tmo_abort got=%b%b%b %h exp=011 00000000",
               bus_req_o, dm_ack_o, err_o, dm_rdata_o);
    end
    dm_req_i = 1'b0;
    tick();
    checks++;
    if ({bus_req_o, dm_ack_o, err_o} !== 3'b000) begin
      failures++;
      $display("FAIL tmo_after got=%b%b%b exp=000",
               bus_req_o, dm_ack_o, err_o);
    end
  endtask

  task automatic test_flush();
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0500;
    flush_i   = 1'b1;
    tick();
    checks++;
    if (bus_req_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle got=%b exp=0", bus_req_o);
    end
    flush_i = 1'b0;
    tick();
    checks++;
    if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h500}) begin
      failures++;
      $display("FAIL flush_grant got=%b %h exp=1 00000500",
               bus_req_o, bus_addr_o);
    end
    flush_i = 1'b1;
    tick();
    flush_i     = 1'b0;
    if_req_i    = 1'b0;
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h0000_0077;
    tick();
    checks++;
    if ({if_ack_o, bus_req_o, err_o, if_rdata_o} !==
        {3'b000, 32'hC0DE_0001}) begin
      failures++;
      $display("FAIL flush_discard got=%b%b%b %h exp=000 c0de0001",
               if_ack_o, bus_req_o, err_o, if_rdata_o);
    end
    bus_ack_i  = 1'b0;
    dm_req_i   = 1'b1;
    dm_we_i    = 1'b1;
    dm_sel_i   = 4'hC;
    dm_addr_i  = 32'h0000_0600;
    dm_wdata_i = 32'h0000_1234;
    tick();
    checks++;
    if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o} !==
        {2'b11, 4'hC, 32'h600}) begin
      failures++;
      $display("FAIL flush_next got=%b%b%h %h exp=11c 00000600",
               bus_req_o, bus_we_o, bus_sel_o, bus_addr_o);
    end
    bus_ack_i = 1'b1;
    tick();
    checks++;
    if ({dm_ack_o, err_o, if_ack_o} !== 3'b100) begin
      failures++;
      $display("FAIL flush_next_ack got=%b%b%b exp=100",
               dm_ack_o, err_o, if_ack_o);
    end
    bus_ack_i = 1'b0;
    dm_req_i  = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h0000_0700;
    tick();
    tick();
    checks++;
    if (bus_req_o !== 1'b1) begin
      failures++;
      $display("FAIL rmid_busy got=%b exp=1", bus_req_o);
    end
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    dm_req_i    = 1'b0;
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h0000_0099;
    tick();
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL rmid_outs got=%h exp=0", outs);
    end
    bus_ack_i = 1'b0;
    tick();
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL rmid_after got=%h exp=0", outs);
    end
  endtask

  initial begin
    rst         = 1'b1;
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    dm_req_i    = 1'b0;
    dm_we_i     = 1'b0;
    dm_sel_i    = '0;
    dm_addr_i   = '0;
    dm_wdata_i  = '0;
    bus_rdata_i = '0;
    bus_ack_i   = 1'b0;
    flush_i     = 1'b0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
